flag_stack_register: RTL
========================

FLAG_STACK_REGISTER -- requirements
Module: flag_stack_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/result width, legal range 2..16.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning flag save-stack entries, legal range 1..16.
REQ-003 The block SHALL have port Clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port Opcode  input  4  ALU operation whose flags are computed.
REQ-006 The block SHALL have port A  input  WIDTH  first operand.
REQ-007 The block SHALL have port B  input  WIDTH  second operand.
REQ-008 The block SHALL have port Update  input  1  commit computed flags and result.
REQ-009 The block SHALL have port Load  input  1  write Load_Data into Flag.
REQ-010 The block SHALL have port Load_Data  input  5  direct flag value.
REQ-011 The block SHALL have port Push  input  1  save Flag onto stack.
REQ-012 The block SHALL have port Pop  input  1  restore Flag from stack.
REQ-013 The block SHALL have port Flag  output  5  [0] Carry, [1] Zero, [2] Sign, [3] Parity, [4] Overflow.
REQ-014 The block SHALL have port Result  output  WIDTH  registered ALU result of last committed operation.
REQ-015 The block SHALL have port Count  output  $clog2(DEPTH+1)  stack occupancy.
REQ-016 The block SHALL have ports Full and Empty  output  1 each  Count==DEPTH and Count==0.
REQ-017 The block SHALL have port Stk_Err  output  1  one-cycle pulse on illegal stack request.

Function
REQ-018 Opcodes SHALL be: 0000 ADD A+B, 0001 SUB A-B, 0010 AND, 0011 OR, 0100 XOR, 0101 INC A+1, 0110 DEC A-1; 0111-1111 unsupported.
REQ-019 Result SHALL be the low WIDTH bits of the operation; Carry = carry-out for ADD/INC, borrow (A<B unsigned, or A==0 for DEC) for SUB/DEC, 0 for logic ops.
REQ-020 Zero SHALL be 1 iff Result==0; Sign SHALL be Result[WIDTH-1]; Parity SHALL be 1 iff Result has an even number of 1 bits (reduction over all WIDTH bits).
REQ-021 Overflow SHALL be two's-complement signed overflow for ADD/SUB/INC/DEC and 0 for logic ops.
REQ-022 With Update=1 and a supported opcode, Flag and Result SHALL take new values at the edge, visible the next cycle (latency 1).
REQ-023 With Update=1 and an unsupported opcode, Flag and Result SHALL hold.
REQ-024 Flag write priority SHALL be Pop (legal) > Load > Update; lower-priority requests in that cycle are discarded; Result updates on Update regardless of priority.
REQ-025 Push (legal) SHALL store the Flag value present before the edge at entry Count and increment Count; a same-cycle Load/Update still modifies Flag.
REQ-026 Pop (legal) SHALL load Flag from entry Count-1 and decrement Count.
REQ-027 Push when Full, Pop when Empty, or Push and Pop together SHALL change neither stack nor Count, SHALL leave Flag as per REQ-024 minus the Pop, and SHALL assert Stk_Err for exactly the next cycle.
REQ-028 Full/Empty SHALL be combinational decodes of registered Count.

Reset
REQ-029 When Rst=1 at an edge, Flag=0, Result=0, Count=0, Stk_Err=0 next cycle, overriding all other inputs; stack contents need not be cleared.
REQ-030 Reset asserted mid-sequence (stack partially full) SHALL leave Empty=1 and a subsequent Pop SHALL give Stk_Err.

Verification (WIDTH=4, DEPTH=4)
REQ-031 ADD A=9 B=8 Update -> Result=1, Flag=5'b10001.
REQ-032 SUB A=5 B=5 Update -> Result=0, Flag=5'b01010; DEC A=0 -> Result=15, Flag=5'b01101.
REQ-033 Load 5'b00111, Push, Load 0, Pop -> Flag=5'b00111, Count 0->1->0, Empty=1.
REQ-034 Five Push cycles -> Count=4, Full=1, Stk_Err pulses once after fifth; Push+Pop same cycle -> Stk_Err, Count unchanged.
REQ-035 Pop on Empty with Update ADD A=1 B=1 -> Stk_Err=1, Flag=5'b00000 from ADD, Result=2.
REQ-036 Count=3 then Rst with Push and Update high -> Flag=0, Result=0, Count=0, Empty=1; Opcode 1111 Update afterward -> all hold.

Source files
------------

// File: rtl/flag_stack_register.sv
// ALU flag register with a small LIFO for saving and restoring flags.
// Result and flags commit on Update; Push/Pop move Flag through the stack.
module flag_stack_register #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [3:0]                   Opcode,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         Update,
  input  logic                         Load,
  input  logic [4:0]                   Load_Data,
  input  logic                         Push,
  input  logic                         Pop,
  output logic [4:0]                   Flag,
  output logic [WIDTH-1:0]             Result,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty,
  output logic                         Stk_Err
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_res;
  logic             carry;
  logic             ovf;
  logic             supported;
  logic [4:0]       new_flag;

  logic [4:0]       stack [DEPTH];
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic             push_ok;
  logic             pop_ok;
  logic             stk_bad;
  logic             commit;

  // Carry for SUB/DEC is the borrow, which falls out of the extra MSB of a zero-extended subtract.
  always_comb begin
    wide      = '0;
    alu_res   = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    supported = 1'b1;
    case (Opcode)
      4'h0: begin
        wide    = {1'b0, A} + {1'b0, B};
        alu_res = wide[WIDTH-1:0];
        carry   = wide[WIDTH];
        ovf     = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      4'h1: begin
        wide    = {1'b0, A} - {1'b0, B};
        alu_res = wide[WIDTH-1:0];
        carry   = wide[WIDTH];
        ovf     = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
      end
      4'h2: alu_res = A & B;
      4'h3: alu_res = A | B;
      4'h4: alu_res = A ^ B;
      4'h5: begin
        wide    = {1'b0, A} + (WIDTH+1)'(1);
        alu_res = wide[WIDTH-1:0];
        carry   = wide[WIDTH];
        ovf     = !A[MSB] && alu_res[MSB];
      end
      4'h6: begin
        wide    = {1'b0, A} - (WIDTH+1)'(1);
        alu_res = wide[WIDTH-1:0];
        carry   = wide[WIDTH];
        ovf     = A[MSB] && !alu_res[MSB];
      end
      default: supported = 1'b0;
    endcase
  end

  assign new_flag = {ovf, ~^alu_res, alu_res[MSB], (alu_res == '0), carry};
  assign commit   = Update && supported;

  assign Full     = (Count == CW'(DEPTH));
  assign Empty    = (Count == '0);
  assign push_ok  = Push && !Pop && !Full;
  assign pop_ok   = Pop && !Push && !Empty;
  assign stk_bad  = (Push && Pop) || (Push && Full) || (Pop && Empty);
  assign push_idx = Count[AW-1:0];
  assign pop_idx  = AW'(Count - CW'(1));

  // A legal pop owns Flag for the cycle; Load beats a computed update.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Flag    <= '0;
      Result  <= '0;
      Count   <= '0;
      Stk_Err <= 1'b0;
    end else begin
      if (commit) Result <= alu_res;
      if (pop_ok)      Flag <= stack[pop_idx];
      else if (Load)   Flag <= Load_Data;
      else if (commit) Flag <= new_flag;
      if (push_ok)     Count <= Count + CW'(1);
      else if (pop_ok) Count <= Count - CW'(1);
      Stk_Err <= stk_bad;
    end
  end

  // Stack storage is not reset; Count alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (!Rst && push_ok) stack[push_idx] <= Flag;
  end

endmodule
